// File: rtl/dff_pipeline_pkg.sv
// Shared definitions for the dff_pipeline register pipeline.
//   clog2       : ceiling log2, used to size the occupancy counter
//   DFLT_WIDTH  : default data width
//   DFLT_DEPTH  : default number of stages
package dff_pipeline_pkg;

    localparam int DFLT_WIDTH = 8;
    localparam int DFLT_DEPTH = 4;

    // Ceiling log2, never less than 1 so a one-value range still gets a bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/dff_pipeline_stage.sv
// One stage of the dff_pipeline: a valid bit plus a data register.
//   clk       in   clock
//   clr       in   synchronous active-high reset (valid -> 0, data -> RESET_VAL)
//   flush     in   discard the held item (valid -> 0, data held)
//   up_valid  in   upstream offers up_data this cycle
//   up_data   in   upstream word
//   dn_ready  in   downstream can take this stage's item this cycle
//   valid     out  stage holds an item
//   data      out  held word
//   ready     out  stage can take an upstream item this cycle
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // An empty stage is always ready, so bubbles collapse even when the
    // downstream end is stalled.
    assign ready = ~valid_q | dn_ready;
    assign valid = valid_q;
    assign data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ready) begin
            valid_d = up_valid;
            // Data only moves with a real item; bubbles leave it untouched.
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dff_pipeline.sv
// WIDTH-bit, DEPTH-stage register pipeline with valid/ready on both ends.
//   clk        in   rising-edge clock
//   clr        in   synchronous active-high reset
//   flush      in   synchronous discard of all held items
//   in_valid   in   producer presents in_data
//   in_ready   out  pipeline accepts in_data this cycle
//   in_data    in   input word
//   out_valid  out  out_data holds a valid item (register of last stage)
//   out_ready  in   consumer takes out_data this cycle
//   out_data   out  output word (register of last stage)
//   count      out  number of occupied stages, 0..DEPTH
module dff_pipeline
    import dff_pipeline_pkg::*;
#(
    parameter int               WIDTH     = DFLT_WIDTH,
    parameter int               DEPTH     = DFLT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    logic             valid_w [DEPTH];
    logic [WIDTH-1:0] data_w  [DEPTH];
    logic             ready_w [DEPTH+1];
    logic             push;

    assign ready_w[DEPTH] = out_ready;
    assign in_ready       = ready_w[0] & ~flush & ~clr;
    assign push           = in_valid & in_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (i == 0) begin : g_head
            assign up_valid = push;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = valid_w[i-1];
            assign up_data  = data_w[i-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .clr      (clr),
            .flush    (flush),
            .up_valid (up_valid),
            .up_data  (up_data),
            .dn_ready (ready_w[i+1]),
            .valid    (valid_w[i]),
            .data     (data_w[i]),
            .ready    (ready_w[i])
        );
    end

    assign out_valid = valid_w[DEPTH-1];
    assign out_data  = data_w[DEPTH-1];

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(valid_w[i]);
        end
    end

endmodule

// File: tb/tb_dff_pipeline.sv
module tb_dff_pipeline;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 4;
    localparam int         CNT_W = 3;
    localparam logic [7:0] RV    = 8'h3C;

    logic             clk = 1'b0;
    logic             clr, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    dff_pipeline #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // Reference model: ordered list of in-flight items with their stage index.
    // Each edge an item advances one stage unless the slot ahead stays occupied.
    typedef struct {
        int         pos;
        logic [7:0] d;
    } item_t;

    item_t      pipe[$];
    logic [7:0] sb[$];
    logic [7:0] last_out;
    bit         model_ok;
    int         n_cmp, n_err, peak;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit iv, input logic [7:0] d, input bit ordy,
                        input bit fl, input bit cl);
        bit e_ir, e_ov;
        int e_cnt, lim, np;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr       = cl;
        e_cnt = pipe.size();
        e_ov  = (e_cnt > 0) && (pipe[0].pos == DEPTH - 1);
        e_ir  = !cl && !fl && (e_cnt < DEPTH || ordy);
        @(negedge clk);
        if (model_ok) begin
            chk("count",     32'(count),     32'(e_cnt));
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("in_ready",  32'(in_ready),  32'(e_ir));
            chk("out_data",  32'(out_data),  32'(last_out));
        end
        if (int'(count) > peak) peak = int'(count);
        @(posedge clk);
        if (cl) begin
            pipe.delete();
            sb.delete();
            last_out = RV;
            model_ok = 1'b1;
        end else if (fl) begin
            pipe.delete();
            sb.delete();
        end else begin
            if (e_ov && ordy) void'(pipe.pop_front());
            for (int k = 0; k < pipe.size(); k++) begin
                lim = (k == 0) ? DEPTH - 1 : pipe[k-1].pos - 1;
                np  = pipe[k].pos + 1;
                if (np > lim) np = lim;
                pipe[k].pos = np;
            end
            if (iv && e_ir) begin
                pipe.push_back('{0, d});
                sb.push_back(d);
            end
            if (pipe.size() > 0 && pipe[0].pos == DEPTH - 1) last_out = pipe[0].d;
        end
        #1;
    endtask

    // Monitor: every completed output handshake is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok && clr === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                chk("sb_has_item", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) chk("sb_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        clr = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        n_cmp = 0; n_err = 0; peak = 0; model_ok = 1'b0; last_out = RV;
        @(posedge clk);
        #1;

        // clr held 3 cycles, then reset values
        repeat (3) step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0);

        // back-to-back pushes with free-running consumer
        peak = 0;
        step(1, 8'h11, 1, 0, 0);
        step(1, 8'h22, 1, 0, 0);
        step(1, 8'h33, 1, 0, 0);
        repeat (6) step(0, 8'h00, 1, 0, 0);
        chk("t2_peak_count", 32'(peak), 32'd3);

        // fill while stalled; 5th push refused
        for (int k = 0; k < 5; k++) step(1, 8'(8'h40 + k), 0, 0, 0);
        repeat (2) step(0, 8'h00, 0, 0, 0);

        // full: simultaneous pop and push
        step(1, 8'h99, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        repeat (8) step(0, 8'h00, 1, 0, 0);

        // bubble collapse under stall
        step(1, 8'hA5, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'h5A, 0, 0, 0);
        repeat (3) step(0, 8'h00, 0, 0, 0);
        repeat (6) step(0, 8'h00, 1, 0, 0);

        // flush with head taken in the same cycle
        step(1, 8'h61, 0, 0, 0);
        step(1, 8'h62, 0, 0, 0);
        step(1, 8'h63, 0, 0, 0);
        repeat (2) step(0, 8'h00, 0, 0, 0);
        step(1, 8'h6F, 1, 1, 0);
        step(1, 8'h70, 1, 0, 0);
        repeat (5) step(0, 8'h00, 1, 0, 0);

        // clr mid-fill
        step(1, 8'h81, 1, 0, 0);
        step(1, 8'h82, 1, 0, 0);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        // randomized traffic
        repeat (800) begin
            step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 59) == 0));
        end

        repeat (10) step(0, 8'h00, 1, 0, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
